// File: rtl/alu_unit_pkg.sv
// alu_unit_pkg: opcode map and widths shared by alu_unit (ALU_PERF_EN enables perf counters)
package alu_unit_pkg;
    localparam int OP_LOG  = 6;
    localparam int ROB_LOG = 4;

    localparam logic [OP_LOG-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_LOG-1:0] OP_LUI   = 6'd1;
    localparam logic [OP_LOG-1:0] OP_AUIPC = 6'd2;
    localparam logic [OP_LOG-1:0] OP_JAL   = 6'd3;
    localparam logic [OP_LOG-1:0] OP_JALR  = 6'd4;
    localparam logic [OP_LOG-1:0] OP_BEQ   = 6'd5;
    localparam logic [OP_LOG-1:0] OP_BNE   = 6'd6;
    localparam logic [OP_LOG-1:0] OP_BLT   = 6'd7;
    localparam logic [OP_LOG-1:0] OP_BGE   = 6'd8;
    localparam logic [OP_LOG-1:0] OP_BLTU  = 6'd9;
    localparam logic [OP_LOG-1:0] OP_BGEU  = 6'd10;
    localparam logic [OP_LOG-1:0] OP_LB    = 6'd11;
    localparam logic [OP_LOG-1:0] OP_LH    = 6'd12;
    localparam logic [OP_LOG-1:0] OP_LW    = 6'd13;
    localparam logic [OP_LOG-1:0] OP_LBU   = 6'd14;
    localparam logic [OP_LOG-1:0] OP_LHU   = 6'd15;
    localparam logic [OP_LOG-1:0] OP_SB    = 6'd16;
    localparam logic [OP_LOG-1:0] OP_SH    = 6'd17;
    localparam logic [OP_LOG-1:0] OP_SW    = 6'd18;
    localparam logic [OP_LOG-1:0] OP_ADDI  = 6'd19;
    localparam logic [OP_LOG-1:0] OP_SLTI  = 6'd20;
    localparam logic [OP_LOG-1:0] OP_SLTIU = 6'd21;
    localparam logic [OP_LOG-1:0] OP_XORI  = 6'd22;
    localparam logic [OP_LOG-1:0] OP_ORI   = 6'd23;
    localparam logic [OP_LOG-1:0] OP_ANDI  = 6'd24;
    localparam logic [OP_LOG-1:0] OP_SLLI  = 6'd25;
    localparam logic [OP_LOG-1:0] OP_SRLI  = 6'd26;
    localparam logic [OP_LOG-1:0] OP_SRAI  = 6'd27;
    localparam logic [OP_LOG-1:0] OP_ADD   = 6'd28;
    localparam logic [OP_LOG-1:0] OP_SUB   = 6'd29;
    localparam logic [OP_LOG-1:0] OP_SLL   = 6'd30;
    localparam logic [OP_LOG-1:0] OP_SLT   = 6'd31;
    localparam logic [OP_LOG-1:0] OP_SLTU  = 6'd32;
    localparam logic [OP_LOG-1:0] OP_XOR   = 6'd33;
    localparam logic [OP_LOG-1:0] OP_SRL   = 6'd34;
    localparam logic [OP_LOG-1:0] OP_SRA   = 6'd35;
    localparam logic [OP_LOG-1:0] OP_OR    = 6'd36;
    localparam logic [OP_LOG-1:0] OP_AND   = 6'd37;
endpackage

// File: rtl/alu_unit_core.sv
// alu_core: combinational RV32I integer/control-flow evaluation for alu_unit
module alu_core
    import alu_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [OP_LOG-1:0] op_i,
    input  logic [XLEN-1:0]   vj_i,
    input  logic [XLEN-1:0]   vk_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic [XLEN-1:0]   value_o,
    output logic              is_jump_o,
    output logic              taken_o,
    output logic [XLEN-1:0]   target_o,
    output logic              supported_o
);
    logic [XLEN-1:0] pc4, rel, jalr_t;
    logic eq, lt, ltu;

    assign pc4    = pc_i + XLEN'(4);
    assign rel    = pc_i + imm_i;
    assign jalr_t = (vj_i + imm_i) & ~XLEN'(1);
    assign eq     = vj_i == vk_i;
    assign lt     = $signed(vj_i) < $signed(vk_i);
    assign ltu    = vj_i < vk_i;

    // decode op into result, jump fields and support flag; taken transfers redirect the target
    always_comb begin
        value_o     = '0;
        is_jump_o   = 1'b0;
        taken_o     = 1'b0;
        target_o    = pc4;
        supported_o = 1'b1;
        case (op_i)
            OP_LUI:   value_o = imm_i;
            OP_AUIPC: value_o = rel;
            OP_JAL:   begin value_o = pc4; is_jump_o = 1'b1; taken_o = 1'b1; end
            OP_JALR:  begin value_o = pc4; is_jump_o = 1'b1; taken_o = 1'b1; end
            OP_BEQ:   begin is_jump_o = 1'b1; taken_o = eq;   end
            OP_BNE:   begin is_jump_o = 1'b1; taken_o = !eq;  end
            OP_BLT:   begin is_jump_o = 1'b1; taken_o = lt;   end
            OP_BGE:   begin is_jump_o = 1'b1; taken_o = !lt;  end
            OP_BLTU:  begin is_jump_o = 1'b1; taken_o = ltu;  end
            OP_BGEU:  begin is_jump_o = 1'b1; taken_o = !ltu; end
            OP_ADDI:  value_o = vj_i + imm_i;
            OP_SLTI:  value_o = XLEN'($signed(vj_i) < $signed(imm_i));
            OP_SLTIU: value_o = XLEN'(vj_i < imm_i);
            OP_XORI:  value_o = vj_i ^ imm_i;
            OP_ORI:   value_o = vj_i | imm_i;
            OP_ANDI:  value_o = vj_i & imm_i;
            OP_SLLI:  value_o = vj_i << imm_i[4:0];
            OP_SRLI:  value_o = vj_i >> imm_i[4:0];
            OP_SRAI:  value_o = $signed(vj_i) >>> imm_i[4:0];
            OP_ADD:   value_o = vj_i + vk_i;
            OP_SUB:   value_o = vj_i - vk_i;
            OP_SLL:   value_o = vj_i << vk_i[4:0];
            OP_SLT:   value_o = XLEN'(lt);
            OP_SLTU:  value_o = XLEN'(ltu);
            OP_XOR:   value_o = vj_i ^ vk_i;
            OP_SRL:   value_o = vj_i >> vk_i[4:0];
            OP_SRA:   value_o = $signed(vj_i) >>> vk_i[4:0];
            OP_OR:    value_o = vj_i | vk_i;
            OP_AND:   value_o = vj_i & vk_i;
            default:  supported_o = 1'b0;
        endcase
        if (taken_o) target_o = (op_i == OP_JALR) ? jalr_t : rel;
    end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: 1-cycle RV32I execute stage broadcasting onto the CDB; ALU_PERF_EN adds perf counters
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int XLEN = 32
`ifdef ALU_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               jump_flag,
    input  logic               FU_enable,
    input  logic [OP_LOG-1:0]  FU_op,
    input  logic [XLEN-1:0]    FU_Vj,
    input  logic [XLEN-1:0]    FU_Vk,
    input  logic [XLEN-1:0]    FU_Imm,
    input  logic [XLEN-1:0]    FU_CurPC,
    input  logic [ROB_LOG-1:0] FU_DestRob,
    output logic               exc_valid,
    output logic [ROB_LOG-1:0] exc_RobId,
    output logic [XLEN-1:0]    exc_value,
    output logic               exc_isJump,
    output logic               exc_taken,
    output logic [XLEN-1:0]    exc_target
`ifdef ALU_PERF_EN
    ,
    output logic [PERF_W-1:0]  perf_exec,
    output logic [PERF_W-1:0]  perf_branch,
    output logic [PERF_W-1:0]  perf_taken
`endif
);
    logic [XLEN-1:0] value_d, target_d;
    logic jump_d, taken_d, sup_d, valid_d;
    logic valid_q, jump_q, taken_q;
    logic [ROB_LOG-1:0] rob_q;
    logic [XLEN-1:0] value_q, target_q;

    alu_core #(.XLEN(XLEN)) u_core (
        .op_i        (FU_op),
        .vj_i        (FU_Vj),
        .vk_i        (FU_Vk),
        .imm_i       (FU_Imm),
        .pc_i        (FU_CurPC),
        .value_o     (value_d),
        .is_jump_o   (jump_d),
        .taken_o     (taken_d),
        .target_o    (target_d),
        .supported_o (sup_d)
    );

    // a flush discards the dispatch in the same cycle; unsupported ops belong to the LSB
    assign valid_d = FU_enable && !jump_flag && sup_d;

    // result register: valid pulses per accepted op, data fields hold between results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            rob_q    <= '0;
            value_q  <= '0;
            jump_q   <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else if (rdy) begin
            valid_q <= valid_d;
            if (valid_d) begin
                rob_q    <= FU_DestRob;
                value_q  <= value_d;
                jump_q   <= jump_d;
                taken_q  <= taken_d;
                target_q <= target_d;
            end
        end
    end

    assign exc_valid  = valid_q;
    assign exc_RobId  = rob_q;
    assign exc_value  = value_q;
    assign exc_isJump = jump_q;
    assign exc_taken  = taken_q;
    assign exc_target = target_q;

`ifdef ALU_PERF_EN
    logic [PERF_W-1:0] exec_q, branch_q, tcnt_q;

    // event counters advance with the result register and share its stall/flush gating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_q   <= '0;
            branch_q <= '0;
            tcnt_q   <= '0;
        end else if (rdy && valid_d) begin
            exec_q   <= exec_q + PERF_W'(1);
            branch_q <= branch_q + PERF_W'(jump_d);
            tcnt_q   <= tcnt_q + PERF_W'(taken_d);
        end
    end

    assign perf_exec   = exec_q;
    assign perf_branch = branch_q;
    assign perf_taken  = tcnt_q;
`endif
endmodule
